// File: rtl/instr_prefetch_pkg.sv
// instr_prefetch_pkg: shared definitions for the instruction prefetcher.
//   RESET_PC_DEFAULT : first fetch address after reset
//   INST_W / ADDR_W  : instruction word and byte-address widths
//   prefetch_state_e : prefetcher FSM states
package instr_prefetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;
  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  // RUN   : requests may issue under the credit rule
  // FLUSH : waiting for responses of requests orphaned by a redirect
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } prefetch_state_e;

endpackage

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: bus bundle around the prefetcher.
//   mem_req_*   : fetch request to instruction memory
//   mem_rsp_*   : in-order responses, one per accepted request
//   inst_*      : head instruction towards decode
//   redirect_*  : control-flow redirect from the control stage
// Handshake semantics: a transfer happens in a cycle where valid && ready are
// both high at posedge clk. Once valid is raised, valid and the payload hold
// until the transfer (the only exception is mem_req_* across a redirect).
// mem_rsp_valid has no ready; the prefetcher always sinks responses.
interface instr_prefetch_if;
  import instr_prefetch_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [INST_W-1:0] mem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  // master: the prefetcher
  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  // slave: memory + decode/control environment
  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_prefetch_inst_fifo.sv
// inst_fifo: instruction queue storing {pc, data} entries.
//   clk, reset : clock, synchronous active-high reset
//   flush      : empties the queue; wins over a same-cycle push/pop
//   push       : write push_data at the tail (allowed when full only with pop)
//   pop        : drop the head entry
//   head_data  : head entry, zero while empty
//   count      : occupancy, 0..DEPTH
module inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage carries no reset; stale words are masked by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential instruction prefetcher with redirect support.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : instr_prefetch_if.master (memory request/response, decode
//                 handshake, redirect)
//   state       : FSM state (RUN / FLUSH)
//   occupancy   : entries held in the instruction queue
//   outstanding : accepted requests whose response will be kept
//   drop_cnt    : accepted requests whose response will be discarded
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_prefetch_if.master       bus,
  output prefetch_state_e        state,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic [$clog2(DEPTH):0] drop_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0]        fetch_pc, fetch_pc_n;
  logic [ADDR_W-1:0]        rsp_pc, rsp_pc_n;
  logic [CW-1:0]            occ_n, outs_n, drop_n;
  prefetch_state_e          state_n;
  logic                     req_valid_n;
  logic                     accept, rsp_drop, rsp_live;
  logic                     push, pop, flush;
  logic [ADDR_W+INST_W-1:0] head;
  logic                     unused_pc_lsb;

  always_comb begin
    accept   = bus.mem_req_valid && bus.mem_req_ready;
    // Responses are in order, so orphaned ones always arrive first.
    rsp_drop = bus.mem_rsp_valid && (drop_cnt != '0);
    rsp_live = bus.mem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);
    flush    = bus.redirect_valid;
    // A redirect discards the same-cycle response and hides the popped head.
    push     = rsp_live && !flush;
    pop      = bus.inst_valid && bus.inst_ready && !flush;
    occ_n    = flush ? '0 : occupancy + CW'(push) - CW'(pop);

    if (flush) begin
      // Everything still in flight after this cycle becomes a drop.
      drop_n     = drop_cnt - CW'(rsp_drop) + outstanding + CW'(accept) - CW'(rsp_live);
      outs_n     = '0;
      fetch_pc_n = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      rsp_pc_n   = fetch_pc_n;
    end else begin
      drop_n     = drop_cnt - CW'(rsp_drop);
      outs_n     = outstanding + CW'(accept) - CW'(rsp_live);
      fetch_pc_n = accept ? fetch_pc + 32'd4 : fetch_pc;
      rsp_pc_n   = rsp_live ? rsp_pc + 32'd4 : rsp_pc;
    end

    state_n = (drop_n != '0) ? FLUSH : RUN;
    // Credit rule evaluated on next-cycle counts so the request is registered.
    req_valid_n = (state_n == RUN) && (({1'b0, occ_n} + {1'b0, outs_n}) < DEPTH_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= RUN;
      fetch_pc          <= RESET_PC;
      rsp_pc            <= RESET_PC;
      outstanding       <= '0;
      drop_cnt          <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
    end else begin
      state             <= state_n;
      fetch_pc          <= fetch_pc_n;
      rsp_pc            <= rsp_pc_n;
      outstanding       <= outs_n;
      drop_cnt          <= drop_n;
      bus.mem_req_valid <= req_valid_n;
      bus.mem_req_addr  <= fetch_pc_n;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + INST_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data ({rsp_pc, bus.mem_rsp_data}),
    .pop       (pop),
    .head_data (head),
    .count     (occupancy)
  );

  assign bus.inst_valid = (occupancy != '0);
  assign bus.inst_pc    = head[ADDR_W+INST_W-1:INST_W];
  assign bus.inst_data  = head[INST_W-1:0];
  assign unused_pc_lsb  = ^bus.redirect_pc[1:0];

`ifndef SYNTHESIS
  // A response with nothing in flight is a memory protocol error.
  rsp_without_request: assert property (@(posedge clk) disable iff (reset)
    !(bus.mem_rsp_valid && (outstanding == '0) && (drop_cnt == '0)));
`endif

endmodule
